// File: rtl/readout_sched.sv
// readout_sched: event readout sequencer for CHAN ADC channels.
// An accepted EOS snapshots CHAN_MASK into a pending set, and the channels in
// that set are then read one at a time, lowest index first. Each read has a
// timeout, and an event can be abandoned by closing the readout window.
//
// Channel handshake (RD_REQUEST / RODONE_n):
//   RD_REQUEST[i] is the request. Once it is raised it stays high and SEL
//   stays fixed until the channel reports completion (RODONE_n[i] low,
//   sampled on a rising CLK edge) or until the timer reaches TIMEOUT. At that
//   edge the request drops. A request is never re-raised without first
//   passing through a one-cycle GAP with RD_REQUEST all-zero.
//
// STATE_DBG exports the FSM state encoding (IDLE=0, SCAN=1, READ=2, GAP=3,
// DONE=4).
module readout_sched #(
   parameter int CHAN    = 8,
   parameter int SEL_W   = 3,
   parameter int TIMEOUT = 4095,
   parameter int TO_W    = 12
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             ZYNQ_RD_EN,
   input  logic             EOS,
   input  logic [CHAN-1:0]  CHAN_MASK,
   input  logic [CHAN-1:0]  RODONE_n,
   output logic [CHAN-1:0]  RD_REQUEST,
   output logic [SEL_W-1:0] SEL,
   output logic             BUSY,
   output logic             SPI_complete,
   output logic             ABORT,
   output logic [CHAN-1:0]  TO_ERR,
   output logic [15:0]      EVT_CNT,
   output logic [2:0]       STATE_DBG
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SCAN = 3'd1,
      S_READ = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   localparam logic [TO_W-1:0] TIMER_MAX = TO_W'(TIMEOUT);

   // Parameter sanity: SEL must address every channel and the timer must
   // be able to hold TIMEOUT.
   generate
      if ((2 ** SEL_W) < CHAN) begin : g_bad_sel_w
         $error("readout_sched: SEL_W too narrow for CHAN");
      end
      if ((2 ** TO_W) <= TIMEOUT) begin : g_bad_to_w
         $error("readout_sched: TO_W too narrow for TIMEOUT");
      end
   endgenerate

   // Internal reset: asserts asynchronously and releases on a CLK edge.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   state_e            state_q, state_d;
   logic [CHAN-1:0]   pending_q, pending_d;
   logic [CHAN-1:0]   rd_req_q, rd_req_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [TO_W-1:0]   timer_q, timer_d;
   logic [CHAN-1:0]   to_err_q, to_err_d;
   logic [15:0]       evt_cnt_q, evt_cnt_d;
   logic              eos_allowed_q, eos_allowed_d;
   logic              abort_q, abort_d;
   logic [SEL_W-1:0]  low_idx;
   logic              eos_accept;
   logic              chan_done;

   // Two-flop reset synchroniser. Assertion passes straight through, and
   // release takes two rising edges.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   // Lowest set index of the pending set, which is the next channel to read.
   always_comb begin
      low_idx = '0;
      for (int i = CHAN - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            low_idx = SEL_W'(i);
         end
      end
   end

   assign eos_accept = ZYNQ_RD_EN && EOS && eos_allowed_q;
   assign chan_done  = !RODONE_n[sel_q];

   // Next-state and datapath updates. Every register holds by default, and
   // ABORT is a one-cycle pulse that defaults low.
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      rd_req_d      = rd_req_q;
      sel_d         = sel_q;
      timer_d       = timer_q;
      to_err_d      = to_err_q;
      evt_cnt_d     = evt_cnt_q;
      eos_allowed_d = eos_allowed_q;
      abort_d       = 1'b0;

      // Closing the window re-arms EOS for the next window.
      if (!ZYNQ_RD_EN) begin
         eos_allowed_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (eos_accept) begin
               pending_d     = CHAN_MASK;
               to_err_d      = '0;
               eos_allowed_d = 1'b0;
               state_d       = S_SCAN;
            end
         end

         S_SCAN: begin
            if (!ZYNQ_RD_EN) begin
               rd_req_d  = '0;
               pending_d = '0;
               abort_d   = 1'b1;
               state_d   = S_IDLE;
            end else if (pending_q == '0) begin
               state_d = S_DONE;
            end else begin
               sel_d             = low_idx;
               rd_req_d          = '0;
               rd_req_d[low_idx] = 1'b1;
               timer_d           = '0;
               state_d           = S_READ;
            end
         end

         S_READ: begin
            if (!ZYNQ_RD_EN) begin
               rd_req_d  = '0;
               pending_d = '0;
               abort_d   = 1'b1;
               state_d   = S_IDLE;
            end else if (chan_done) begin
               // Completion takes priority over a simultaneous timeout.
               rd_req_d         = '0;
               pending_d[sel_q] = 1'b0;
               state_d          = S_GAP;
            end else if (timer_q == TIMER_MAX) begin
               rd_req_d         = '0;
               pending_d[sel_q] = 1'b0;
               to_err_d[sel_q]  = 1'b1;
               state_d          = S_GAP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_GAP: begin
            if (!ZYNQ_RD_EN) begin
               rd_req_d  = '0;
               pending_d = '0;
               abort_d   = 1'b1;
               state_d   = S_IDLE;
            end else begin
               state_d = S_SCAN;
            end
         end

         S_DONE: begin
            evt_cnt_d = evt_cnt_q + 16'd1;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, all cleared by the internal reset.
   always_ff @(posedge CLK or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q       <= S_IDLE;
         pending_q     <= '0;
         rd_req_q      <= '0;
         sel_q         <= '0;
         timer_q       <= '0;
         to_err_q      <= '0;
         evt_cnt_q     <= '0;
         eos_allowed_q <= 1'b1;
         abort_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         rd_req_q      <= rd_req_d;
         sel_q         <= sel_d;
         timer_q       <= timer_d;
         to_err_q      <= to_err_d;
         evt_cnt_q     <= evt_cnt_d;
         eos_allowed_q <= eos_allowed_d;
         abort_q       <= abort_d;
      end
   end

   assign RD_REQUEST   = rd_req_q;
   assign SEL          = sel_q;
   assign BUSY         = (state_q != S_IDLE);
   assign SPI_complete = (state_q == S_DONE);
   assign ABORT        = abort_q;
   assign TO_ERR       = to_err_q;
   assign EVT_CNT      = evt_cnt_q;
   assign STATE_DBG    = state_q;

endmodule
